riscv_i32_mem_stage: RTL and testbench

//  Memory/writeback stage directly downstream of the i32 ALU. Takes one executed instruction
//  (ALU result, effective address, rs2, decode fields), issues load/store on a valid/ack data-memory

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/riscv_i32_mem_stage_if.sv | 23 ++
 rtl/riscv_i32_load_align.sv | 27 ++
 rtl/riscv_i32_mem_stage.sv | 212 +++++++++++++++++++++
 tb/tb_riscv_i32_mem_stage.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V i32 definitions: op codes, memory widths, cause codes and
// the data-memory request / writeback record types used by the memory stage.
package riscv_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;

  typedef enum logic [1:0] {
    MW_BYTE  = 2'd0,
    MW_HALF  = 2'd1,
    MW_WORD  = 2'd2,
    MW_WORD3 = 2'd3
  } mem_width_e;

  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    logic        read_not_write;
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
  } dmem_req_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        rd_written;
    logic [31:0] data;
    logic        exception;
    logic [3:0]  cause;
  } wb_t;

endpackage

// File: rtl/riscv_i32_mem_stage_if.sv
// Data-memory valid/ack request port plus single-cycle read response.
interface riscv_i32_mem_stage_if;
  logic        dmem_req__valid;
  logic        dmem_req__read_not_write;
  logic [31:0] dmem_req__address;
  logic [3:0]  dmem_req__byte_enable;
  logic [31:0] dmem_req__write_data;
  logic        dmem_req_ack;
  logic        dmem_resp__valid;
  logic [31:0] dmem_resp__read_data;

  modport master (
    output dmem_req__valid, dmem_req__read_not_write, dmem_req__address,
           dmem_req__byte_enable, dmem_req__write_data,
    input  dmem_req_ack, dmem_resp__valid, dmem_resp__read_data
  );

  modport slave (
    input  dmem_req__valid, dmem_req__read_not_write, dmem_req__address,
           dmem_req__byte_enable, dmem_req__write_data,
    output dmem_req_ack, dmem_resp__valid, dmem_resp__read_data
  );
endinterface

// File: rtl/riscv_i32_load_align.sv
// Combinational load aligner: selects the addressed byte/half/word lane of a
// word-aligned read and sign- or zero-extends it to 32 bits.
module riscv_i32_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] read_data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic        read_unsigned,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = read_data >> {addr_lo, 3'b000};
    result  = shifted;
    case (mem_width_e'(width))
      MW_BYTE: result = read_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      MW_HALF: result = read_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/riscv_i32_mem_stage.sv
// Memory/writeback stage: issues loads/stores on the dmem port, aligns load
// data and emits one registered writeback record per accepted instruction.
module riscv_i32_mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_op,
  input  logic [1:0]  ex_memory_width,
  input  logic        ex_memory_read_unsigned,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rd_written,
  input  logic [31:0] alu_result__result,
  input  logic [31:0] alu_result__arith_result,
  input  logic [31:0] ex_rs2,

  riscv_i32_mem_stage_if.master dmem,

  output logic        wb__valid,
  output logic [4:0]  wb__rd,
  output logic        wb__rd_written,
  output logic [31:0] wb__data,
  output logic        wb__exception,
  output logic [3:0]  wb__cause
);

  localparam logic [7:0] TIMEOUT = 8'(RESP_TIMEOUT);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d;
  wb_t         wb_q, wb_d;

  logic        is_load_q, is_load_d;
  logic [1:0]  width_q, width_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_wr_q, rd_wr_d;

  logic [31:0] load_data;
  logic        ex_is_mem;
  logic        ex_is_load;
  logic        misaligned;
  logic [3:0]  be;
  logic [31:0] wdata;

  riscv_i32_load_align u_load_align (
    .read_data     (dmem.dmem_resp__read_data),
    .addr_lo       (addr_lo_q),
    .width         (width_q),
    .read_unsigned (unsigned_q),
    .result        (load_data)
  );

  // Decode of the instruction currently offered by execute.
  always_comb begin
    ex_is_load = (ex_op == OP_LOAD);
    ex_is_mem  = ex_is_load || (ex_op == OP_STORE);
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = ex_rs2;
    case (mem_width_e'(ex_memory_width))
      MW_BYTE: begin
        be    = 4'b0001 << alu_result__arith_result[1:0];
        wdata = {4{ex_rs2[7:0]}};
      end
      MW_HALF: begin
        misaligned = alu_result__arith_result[0];
        be         = 4'b0011 << {alu_result__arith_result[1], 1'b0};
        wdata      = {2{ex_rs2[15:0]}};
      end
      default: misaligned = (alu_result__arith_result[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    wb_d       = '0;
    is_load_d  = is_load_q;
    width_d    = width_q;
    unsigned_d = unsigned_q;
    addr_lo_d  = addr_lo_q;
    rd_d       = rd_q;
    rd_wr_d    = rd_wr_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        req_d = '0;
        if (ex_valid) begin
          is_load_d  = ex_is_load;
          width_d    = ex_memory_width;
          unsigned_d = ex_memory_read_unsigned;
          addr_lo_d  = alu_result__arith_result[1:0];
          rd_d       = ex_rd;
          rd_wr_d    = ex_rd_written;
          if (!ex_is_mem) begin
            wb_d.valid      = 1'b1;
            wb_d.rd         = ex_rd;
            wb_d.rd_written = ex_rd_written;
            wb_d.data       = alu_result__result;
          end else if (misaligned) begin
            wb_d.valid     = 1'b1;
            wb_d.rd        = ex_rd;
            wb_d.exception = 1'b1;
            wb_d.cause     = ex_is_load ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;
          end else begin
            state_d              = ST_REQ;
            req_d.valid          = 1'b1;
            req_d.read_not_write = ex_is_load;
            req_d.address        = {alu_result__arith_result[31:2], 2'b00};
            req_d.byte_enable    = be;
            req_d.write_data     = ex_is_load ? '0 : wdata;
          end
        end
      end

      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (dmem.dmem_req_ack) begin
          req_d = '0;
          if (is_load_q) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_IDLE;
            wb_d.valid = 1'b1;
            wb_d.rd    = rd_q;
          end
        end else if (cnt_d >= TIMEOUT) begin
          state_d        = ST_IDLE;
          req_d          = '0;
          wb_d.valid     = 1'b1;
          wb_d.rd        = rd_q;
          wb_d.exception = 1'b1;
          wb_d.cause     = is_load_q ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
        end
      end

      ST_RESP: begin
        cnt_d = cnt_q + 8'd1;
        if (dmem.dmem_resp__valid) begin
          state_d         = ST_IDLE;
          wb_d.valid      = 1'b1;
          wb_d.rd         = rd_q;
          wb_d.rd_written = rd_wr_q;
          wb_d.data       = load_data;
        end else if (cnt_d >= TIMEOUT) begin
          state_d        = ST_IDLE;
          wb_d.valid     = 1'b1;
          wb_d.rd        = rd_q;
          wb_d.exception = 1'b1;
          wb_d.cause     = CAUSE_LOAD_FAULT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      wb_q       <= '0;
      is_load_q  <= 1'b0;
      width_q    <= '0;
      unsigned_q <= 1'b0;
      addr_lo_q  <= '0;
      rd_q       <= '0;
      rd_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      wb_q       <= wb_d;
      is_load_q  <= is_load_d;
      width_q    <= width_d;
      unsigned_q <= unsigned_d;
      addr_lo_q  <= addr_lo_d;
      rd_q       <= rd_d;
      rd_wr_q    <= rd_wr_d;
    end
  end

  assign ex_ready = (state_q == ST_IDLE);

  assign dmem.dmem_req__valid          = req_q.valid;
  assign dmem.dmem_req__read_not_write = req_q.read_not_write;
  assign dmem.dmem_req__address        = req_q.address;
  assign dmem.dmem_req__byte_enable    = req_q.byte_enable;
  assign dmem.dmem_req__write_data     = req_q.write_data;

  assign wb__valid      = wb_q.valid;
  assign wb__rd         = wb_q.rd;
  assign wb__rd_written = wb_q.rd_written;
  assign wb__data       = wb_q.data;
  assign wb__exception  = wb_q.exception;
  assign wb__cause      = wb_q.cause;

endmodule

// File: tb/tb_riscv_i32_mem_stage.sv
// Directed bench for riscv_i32_mem_stage: pass-through, aligned loads/stores,
// misalignment, withheld ack, response timeout and reset mid-access.
module tb_riscv_i32_mem_stage;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_op;
  logic [1:0]  ex_memory_width;
  logic        ex_memory_read_unsigned;
  logic [4:0]  ex_rd;
  logic        ex_rd_written;
  logic [31:0] alu_result__result;
  logic [31:0] alu_result__arith_result;
  logic [31:0] ex_rs2;
  logic        wb__valid;
  logic [4:0]  wb__rd;
  logic        wb__rd_written;
  logic [31:0] wb__data;
  logic        wb__exception;
  logic [3:0]  wb__cause;

  int unsigned n_checks;
  int unsigned n_errors;

  riscv_i32_mem_stage_if dmem ();

  riscv_i32_mem_stage #(.RESP_TIMEOUT(4)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .ex_valid                 (ex_valid),
    .ex_ready                 (ex_ready),
    .ex_op                    (ex_op),
    .ex_memory_width          (ex_memory_width),
    .ex_memory_read_unsigned  (ex_memory_read_unsigned),
    .ex_rd                    (ex_rd),
    .ex_rd_written            (ex_rd_written),
    .alu_result__result       (alu_result__result),
    .alu_result__arith_result (alu_result__arith_result),
    .ex_rs2                   (ex_rs2),
    .dmem                     (dmem.master),
    .wb__valid                (wb__valid),
    .wb__rd                   (wb__rd),
    .wb__rd_written           (wb__rd_written),
    .wb__data                 (wb__data),
    .wb__exception            (wb__exception),
    .wb__cause                (wb__cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] op, input logic [1:0] width, input logic uns,
                       input logic [4:0] rd, input logic rdw, input logic [31:0] res,
                       input logic [31:0] addr, input logic [31:0] rs2);
    ex_valid                 = 1'b1;
    ex_op                    = op;
    ex_memory_width          = width;
    ex_memory_read_unsigned  = uns;
    ex_rd                    = rd;
    ex_rd_written            = rdw;
    alu_result__result       = res;
    alu_result__arith_result = addr;
    ex_rs2                   = rs2;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0;
    ex_op    = 4'h0;
  endtask

  // Runs one aligned load: accept, ack on the first request cycle, response next.
  task automatic do_load(input string tag, input logic [1:0] width, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    offer(4'h6, width, uns, 5'd9, 1'b1, 32'h0, addr, 32'h0);
    tick();
    idle_ex();
    check({tag, " req_valid"}, 32'(dmem.dmem_req__valid), 32'd1);
    check({tag, " rnw"}, 32'(dmem.dmem_req__read_not_write), 32'd1);
    check({tag, " addr"}, dmem.dmem_req__address, {addr[31:2], 2'b00});
    check({tag, " be"}, 32'(dmem.dmem_req__byte_enable), 32'(exp_be));
    dmem.dmem_req_ack = 1'b1;
    tick();
    dmem.dmem_req_ack = 1'b0;
    check({tag, " wb_early"}, 32'(wb__valid), 32'd0);
    dmem.dmem_resp__valid     = 1'b1;
    dmem.dmem_resp__read_data = rdata;
    tick();
    dmem.dmem_resp__valid = 1'b0;
    check({tag, " wb_valid"}, 32'(wb__valid), 32'd1);
    check({tag, " wb_data"}, wb__data, exp_data);
    check({tag, " wb_rdw"}, 32'(wb__rd_written), 32'd1);
    tick();
    check({tag, " wb_pulse"}, 32'(wb__valid), 32'd0);
  endtask

  initial begin
    int unsigned waited;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    idle_ex();
    ex_memory_width          = 2'd0;
    ex_memory_read_unsigned  = 1'b0;
    ex_rd                    = 5'd0;
    ex_rd_written            = 1'b0;
    alu_result__result       = 32'h0;
    alu_result__arith_result = 32'h0;
    ex_rs2                   = 32'h0;
    dmem.dmem_req_ack         = 1'b0;
    dmem.dmem_resp__valid     = 1'b0;
    dmem.dmem_resp__read_data = 32'h0;

    tick();
    tick();
    check("rst ex_ready", 32'(ex_ready), 32'd1);
    check("rst req_valid", 32'(dmem.dmem_req__valid), 32'd0);
    check("rst wb_valid", 32'(wb__valid), 32'd0);
    check("rst wb_data", wb__data, 32'h0);
    reset_n = 1'b1;
    tick();

    // Two back-to-back pass-throughs; the second is accepted while the first pulses.
    offer(4'h1, 2'd2, 1'b0, 5'd5, 1'b1, 32'h1000_0004, 32'h0, 32'h0);
    tick();
    check("pt wb_valid", 32'(wb__valid), 32'd1);
    check("pt wb_data", wb__data, 32'h1000_0004);
    check("pt wb_rd", 32'(wb__rd), 32'd5);
    check("pt wb_rdw", 32'(wb__rd_written), 32'd1);
    check("pt ex_ready", 32'(ex_ready), 32'd1);
    offer(4'h2, 2'd2, 1'b0, 5'd6, 1'b1, 32'hCAFE_0001, 32'h0, 32'h0);
    tick();
    idle_ex();
    check("pt2 wb_valid", 32'(wb__valid), 32'd1);
    check("pt2 wb_data", wb__data, 32'hCAFE_0001);
    tick();
    check("pt2 pulse", 32'(wb__valid), 32'd0);

    do_load("lb", 2'd0, 1'b0, 32'h0000_0203, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 2'd0, 1'b1, 32'h0000_0203, 32'h8012_3456, 4'b1000, 32'h0000_0080);
    do_load("lh", 2'd1, 1'b0, 32'h0000_0202, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    do_load("lw", 2'd2, 1'b0, 32'h0000_0204, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    // Store half with ack withheld for three request cycles.
    offer(4'h7, 2'd1, 1'b0, 5'd3, 1'b1, 32'h0, 32'h0000_0102, 32'hDEAD_BEEF);
    tick();
    idle_ex();
    for (int i = 0; i < 3; i++) begin
      check("sh addr", dmem.dmem_req__address, 32'h0000_0100);
      check("sh be", 32'(dmem.dmem_req__byte_enable), 32'b1100);
      check("sh wdata", dmem.dmem_req__write_data, 32'hBEEF_BEEF);
      check("sh rnw", 32'(dmem.dmem_req__read_not_write), 32'd0);
      check("sh valid", 32'(dmem.dmem_req__valid), 32'd1);
      check("sh ex_ready", 32'(ex_ready), 32'd0);
      tick();
    end
    dmem.dmem_req_ack = 1'b1;
    tick();
    dmem.dmem_req_ack = 1'b0;
    check("sh wb_valid", 32'(wb__valid), 32'd1);
    check("sh wb_rdw", 32'(wb__rd_written), 32'd0);
    check("sh wb_exc", 32'(wb__exception), 32'd0);
    check("sh req_drop", 32'(dmem.dmem_req__valid), 32'd0);
    check("sh ex_ready", 32'(ex_ready), 32'd1);

    // Store byte with immediate ack: latency 2.
    offer(4'h7, 2'd0, 1'b0, 5'd4, 1'b1, 32'h0, 32'h0000_0101, 32'h1234_56A5);
    tick();
    idle_ex();
    check("sb be", 32'(dmem.dmem_req__byte_enable), 32'b0010);
    check("sb wdata", dmem.dmem_req__write_data, 32'hA5A5_A5A5);
    dmem.dmem_req_ack = 1'b1;
    tick();
    dmem.dmem_req_ack = 1'b0;
    check("sb wb_valid", 32'(wb__valid), 32'd1);
    check("sb wb_rdw", 32'(wb__rd_written), 32'd0);

    // Misaligned word load and half store.
    offer(4'h6, 2'd2, 1'b0, 5'd7, 1'b1, 32'h0, 32'h0000_0201, 32'h0);
    tick();
    idle_ex();
    check("lwmis req", 32'(dmem.dmem_req__valid), 32'd0);
    check("lwmis wb_valid", 32'(wb__valid), 32'd1);
    check("lwmis exc", 32'(wb__exception), 32'd1);
    check("lwmis cause", 32'(wb__cause), 32'd4);
    check("lwmis rdw", 32'(wb__rd_written), 32'd0);
    offer(4'h7, 2'd1, 1'b0, 5'd7, 1'b1, 32'h0, 32'h0000_0103, 32'h0);
    tick();
    idle_ex();
    check("shmis req", 32'(dmem.dmem_req__valid), 32'd0);
    check("shmis cause", 32'(wb__cause), 32'd6);
    check("shmis exc", 32'(wb__exception), 32'd1);

    // Load never acked: fault after RESP_TIMEOUT=4 request cycles.
    offer(4'h6, 2'd2, 1'b0, 5'd8, 1'b1, 32'h0, 32'h0000_0300, 32'h0);
    tick();
    idle_ex();
    waited = 0;
    while (!wb__valid && waited < 10) begin
      tick();
      waited++;
    end
    check("tmo wb_valid", 32'(wb__valid), 32'd1);
    check("tmo cycles", waited, 32'd4);
    check("tmo exc", 32'(wb__exception), 32'd1);
    check("tmo cause", 32'(wb__cause), 32'd5);
    check("tmo rdw", 32'(wb__rd_written), 32'd0);
    check("tmo req_drop", 32'(dmem.dmem_req__valid), 32'd0);
    check("tmo ex_ready", 32'(ex_ready), 32'd1);

    // Reset while in RESP; late response after release is ignored.
    offer(4'h6, 2'd2, 1'b0, 5'd10, 1'b1, 32'h0, 32'h0000_0400, 32'h0);
    tick();
    idle_ex();
    dmem.dmem_req_ack = 1'b1;
    tick();
    dmem.dmem_req_ack = 1'b0;
    check("rr in_resp", 32'(ex_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rr async req", 32'(dmem.dmem_req__valid), 32'd0);
    check("rr async ready", 32'(ex_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    dmem.dmem_resp__valid     = 1'b1;
    dmem.dmem_resp__read_data = 32'h5555_AAAA;
    tick();
    dmem.dmem_resp__valid = 1'b0;
    check("rr wb_valid", 32'(wb__valid), 32'd0);
    check("rr wb_data", wb__data, 32'h0);
    check("rr ex_ready", 32'(ex_ready), 32'd1);
    check("rr req", 32'(dmem.dmem_req__valid), 32'd0);
    check("rr addr", dmem.dmem_req__address, 32'h0);
    tick();
    check("rr wb_valid2", 32'(wb__valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
